dm_responder: RTL

- Data-side responder for the single-cycle core. Serves the core's data port (address, write data, write enable) and returns read data in the same cycle.
- Decodes each address into one of three targets:
  - word RAM;
  - memory-mapped I/O block (LED, switches, countdown timer);
  - unmapped space.
- Sits between the core top and the board I/O.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_timer.sv | 79 +++++++
 rtl/dm_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-side responder: MMIO offsets, timer CTRL bits
// and the address region type used by the decoder.
package dm_pkg;

  localparam logic [11:0] OFF_TCNT  = 12'h020;
  localparam logic [11:0] OFF_TRLD  = 12'h024;
  localparam logic [11:0] OFF_TCTRL = 12'h028;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_EXP = 1;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_e;

  // Word offsets inside the window ignore the byte bits of the address.
  function automatic logic off_hit(logic [11:2] word_off, logic [11:0] off);
    return {word_off, 2'b00} == off;
  endfunction

endpackage

// File: rtl/dm_timer.sv
// Countdown timer for the MMIO window: prescaler, COUNT, RELOAD and CTRL
// (EN, sticky EXPIRED). Only built when DM_TIMER_EN is defined.
module dm_timer
  import dm_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [11:2] off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   rld_q, rld_d;
  logic          en_q, en_d;
  logic          exp_q, exp_d;
  logic          tick;
  logic          expire;

  always_comb begin
    tick   = en_q && (pre_q == PRE_LAST);
    expire = tick && (cnt_q == '0);
    pre_d  = '0;
    if (en_q && !tick) pre_d = pre_q + PW'(1);
    cnt_d = cnt_q;
    if (tick) cnt_d = expire ? rld_q : cnt_q - 32'd1;
    rld_d = rld_q;
    en_d  = en_q;
    exp_d = exp_q;
    // A RELOAD write overrides whatever the tick did to COUNT this edge.
    if (we && off_hit(off, OFF_TRLD)) begin
      rld_d = wdata;
      cnt_d = wdata;
    end
    if (we && off_hit(off, OFF_TCTRL)) begin
      en_d = wdata[CTRL_EN];
      if (wdata[CTRL_EXP]) exp_d = 1'b0;
    end
    // Expiry beats a simultaneous write-1-clear.
    if (expire) exp_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      rld_q <= '0;
      en_q  <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      rld_q <= rld_d;
      en_q  <= en_d;
      exp_q <= exp_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (off_hit(off, OFF_TCNT)) rdata = cnt_q;
    else if (off_hit(off, OFF_TRLD)) rdata = rld_q;
    else if (off_hit(off, OFF_TCTRL)) begin
      rdata[CTRL_EN]  = en_q;
      rdata[CTRL_EXP] = exp_q;
    end
  end

  assign irq = exp_q;

endmodule

// File: rtl/dm_responder.sv
// Data-port responder: word RAM, MMIO (LED, switches, timer) and unmapped space,
// with combinational reads. The timer is built only when DM_TIMER_EN is defined.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000,
  parameter int          PRESCALE = 100,
  parameter int          SW_W     = 24,
  parameter int          LED_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memRW,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  region_e           region;
  logic [11:2]       io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              io_we;
  logic [31:0]       tmr_rdata;
  logic [31:0]       ram_q [2**RAM_AW];
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]   sw_sync_q, sw_sync_d;
  logic              unused_bits;

  always_comb begin
    if (addr[31:12] == IO_BASE[31:12]) region = REG_IO;
    else if (addr[31:RAM_AW+2] == '0) region = REG_RAM;
    else region = REG_NONE;
  end

  assign io_off      = addr[11:2];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign io_we       = memRW && (region == REG_IO);
  assign unused_bits = ^{addr[1:0], wdata};

  // RAM has no reset, so writes land even while rst is high.
  always_ff @(posedge clk) begin
    if (memRW && (region == REG_RAM)) ram_q[ram_idx] <= wdata;
  end

  always_comb begin
    led_d     = led_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    if (io_we && off_hit(io_off, OFF_LED)) led_d = wdata[LED_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign led = led_q;

`ifdef DM_TIMER_EN
  dm_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .we    (io_we),
    .off   (io_off),
    .wdata (wdata),
    .rdata (tmr_rdata),
    .irq   (irq)
  );
`else
  assign tmr_rdata = '0;
  assign irq       = 1'b0;
`endif

  // Timer read mux already returns 0 for every offset it does not own.
  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM: rdata = ram_q[ram_idx];
      REG_IO: begin
        if (off_hit(io_off, OFF_LED)) rdata = 32'(led_q);
        else if (off_hit(io_off, OFF_SW)) rdata = 32'(sw_sync_q);
        else rdata = tmr_rdata;
      end
      default: rdata = '0;
    endcase
  end

endmodule
